// File: rtl/operand_sel_reg_pkg.sv
// Shared pipeline constants: word width, forwarding select encodings, default error counter width.
package pipe_pkg;

   localparam int unsigned WORD_W    = 32;
   localparam int unsigned ERR_W_DEF = 8;

   typedef enum logic [1:0] {
      FWD_REG = 2'd0,
      FWD_MEM = 2'd1,
      FWD_WB  = 2'd2
   } fwd_sel_e;

endpackage

// File: rtl/operand_sel_reg_if.sv
// Operand selector bus: sources, select and pipeline controls in; registered operand out.
interface operand_sel_reg_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N_IN  = 3,
   parameter int unsigned ERR_W = 8
);
   localparam int unsigned SEL_W = $clog2(N_IN);

   logic [N_IN*WIDTH-1:0] data_in;
   logic [SEL_W-1:0]      sel;
   logic                  in_valid;
   logic                  stall;
   logic                  flush;
   logic [WIDTH-1:0]      data_out;
   logic                  out_valid;
   logic                  sel_err;
   logic [ERR_W-1:0]      err_cnt;

   modport master (
      output data_in, sel, in_valid, stall, flush,
      input  data_out, out_valid, sel_err, err_cnt
   );

   modport slave (
      input  data_in, sel, in_valid, stall, flush,
      output data_out, out_valid, sel_err, err_cnt
   );

endinterface

// File: rtl/operand_sel_reg_sel_core.sv
// Combinational indexed word select with an in-range flag for the requested source.
module sel_core #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N_IN  = 3,
   localparam int unsigned SEL_W = $clog2(N_IN)
) (
   input  logic [N_IN*WIDTH-1:0] data_in,
   input  logic [SEL_W-1:0]      sel,
   output logic [WIDTH-1:0]      data,
   output logic                  in_range
);

   // Codes with no matching source leave data at zero and in_range low.
   always_comb begin
      data     = '0;
      in_range = 1'b0;
      for (int k = 0; k < N_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            data     = data_in[k*WIDTH +: WIDTH];
            in_range = 1'b1;
         end
      end
   end

endmodule

// File: rtl/operand_sel_reg.sv
// Registered N-to-1 operand selector with valid tracking, stall hold, flush bubble and OOR tally.
module operand_sel_reg
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH    = WORD_W,
   parameter int unsigned N_IN     = 3,
   parameter int unsigned OOR_HOLD = 0,
   parameter int unsigned ERR_W    = ERR_W_DEF
) (
   input logic             clk,
   input logic             rst,
   operand_sel_reg_if.slave bus
);

   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   logic [WIDTH-1:0] sel_data;
   logic             in_range;

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic [ERR_W-1:0] cnt_q, cnt_d;

   sel_core #(
      .WIDTH (WIDTH),
      .N_IN  (N_IN)
   ) u_sel_core (
      .data_in  (bus.data_in),
      .sel      (bus.sel),
      .data     (sel_data),
      .in_range (in_range)
   );

   // Priority below rst: flush, then stall, then load.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      if (bus.flush) begin
         data_d  = '0;
         valid_d = 1'b0;
         err_d   = 1'b0;
      end else if (!bus.stall) begin
         valid_d = bus.in_valid;
         if (!bus.in_valid) begin
            data_d = '0;
            err_d  = 1'b0;
         end else if (in_range) begin
            data_d = sel_data;
            err_d  = 1'b0;
         end else begin
            err_d = 1'b1;
            if (cnt_q != ERR_MAX) cnt_d = cnt_q + ERR_W'(1);
            if (OOR_HOLD == 0) data_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.data_out  = data_q;
   assign bus.out_valid = valid_q;
   assign bus.sel_err   = err_q;
   assign bus.err_cnt   = cnt_q;

endmodule

// File: tb/tb_operand_sel_reg.sv
// Scoreboard bench for operand_sel_reg across three parameter sets.
module tb_operand_sel_reg;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   operand_sel_reg_if #(.WIDTH(32), .N_IN(3), .ERR_W(8)) bus_a ();
   operand_sel_reg_if #(.WIDTH(32), .N_IN(3), .ERR_W(2)) bus_b ();
   operand_sel_reg_if #(.WIDTH(8),  .N_IN(4), .ERR_W(8)) bus_c ();

   operand_sel_reg #(.WIDTH(32), .N_IN(3), .OOR_HOLD(0), .ERR_W(8)) dut_a (
      .clk (clk), .rst (rst), .bus (bus_a.slave)
   );
   operand_sel_reg #(.WIDTH(32), .N_IN(3), .OOR_HOLD(1), .ERR_W(2)) dut_b (
      .clk (clk), .rst (rst), .bus (bus_b.slave)
   );
   operand_sel_reg #(.WIDTH(8), .N_IN(4), .OOR_HOLD(0), .ERR_W(8)) dut_c (
      .clk (clk), .rst (rst), .bus (bus_c.slave)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        valid;
      logic        err;
      logic [7:0]  cnt;
   } exp_t;

   typedef struct packed {
      logic        r, fl, st, iv;
      logic [1:0]  s;
      logic [31:0] d0, d1, d2;
   } stim_t;

   exp_t      q_a[$];
   exp_t      q_b[$];
   logic [7:0] q_c[$];
   exp_t      m_a = '0;
   exp_t      m_b = '0;

   function automatic stim_t mk(logic r, logic fl, logic st, logic iv, logic [1:0] s,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2);
      stim_t t;
      t.r = r; t.fl = fl; t.st = st; t.iv = iv; t.s = s;
      t.d0 = d0; t.d1 = d1; t.d2 = d2;
      return t;
   endfunction

   // Expected register contents after one edge, for a 3-source instance.
   function automatic exp_t model(exp_t cur, stim_t t, int hold, logic [7:0] cmax);
      exp_t n = cur;
      if (t.r) n = '0;
      else if (t.fl) begin
         n.valid = 1'b0; n.err = 1'b0; n.data = '0;
      end else if (!t.st) begin
         n.valid = t.iv;
         if (!t.iv) begin
            n.data = '0; n.err = 1'b0;
         end else if (t.s == 2'd0) begin
            n.data = t.d0; n.err = 1'b0;
         end else if (t.s == 2'd1) begin
            n.data = t.d1; n.err = 1'b0;
         end else if (t.s == 2'd2) begin
            n.data = t.d2; n.err = 1'b0;
         end else begin
            n.err = 1'b1;
            if (n.cnt < cmax) n.cnt = n.cnt + 8'd1;
            if (hold == 0) n.data = '0;
         end
      end
      return n;
   endfunction

   task automatic drive_a(input stim_t t);
      @(negedge clk);
      rst            = t.r;
      bus_a.flush    = t.fl;
      bus_a.stall    = t.st;
      bus_a.in_valid = t.iv;
      bus_a.sel      = t.s;
      bus_a.data_in  = {t.d2, t.d1, t.d0};
      bus_b.in_valid = 1'b0;
      bus_b.stall    = 1'b0;
      bus_b.flush    = 1'b0;
      m_a = model(m_a, t, 0, 8'd255);
      m_b = model(m_b, mk(t.r, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 0), 1, 8'd3);
      q_a.push_back(m_a);
   endtask

   task automatic drive_b(input stim_t t);
      @(negedge clk);
      rst            = t.r;
      bus_b.flush    = t.fl;
      bus_b.stall    = t.st;
      bus_b.in_valid = t.iv;
      bus_b.sel      = t.s;
      bus_b.data_in  = {t.d2, t.d1, t.d0};
      bus_a.in_valid = 1'b0;
      bus_a.stall    = 1'b0;
      bus_a.flush    = 1'b0;
      m_b = model(m_b, t, 1, 8'd3);
      m_a = model(m_a, mk(t.r, 1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 0), 0, 8'd255);
      q_b.push_back(m_b);
   endtask

   task automatic run_a(input string name, input stim_t st[$]);
      exp_t e, g;
      foreach (st[i]) begin
         drive_a(st[i]);
         @(posedge clk); #1;
         e = q_a.pop_front();
         g = {bus_a.data_out, bus_a.out_valid, bus_a.sel_err, bus_a.err_cnt};
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL %s step %0d: got data=%h v=%b e=%b cnt=%0d, want data=%h v=%b e=%b cnt=%0d",
                     name, i, g.data, g.valid, g.err, g.cnt, e.data, e.valid, e.err, e.cnt);
         end
      end
   endtask

   task automatic run_b(input string name, input stim_t st[$]);
      exp_t e, g;
      foreach (st[i]) begin
         drive_b(st[i]);
         @(posedge clk); #1;
         e = q_b.pop_front();
         g = {bus_b.data_out, bus_b.out_valid, bus_b.sel_err, 6'd0, bus_b.err_cnt};
         checks++;
         if (g !== e) begin
            failures++;
            $display("FAIL %s step %0d: got data=%h v=%b e=%b cnt=%0d, want data=%h v=%b e=%b cnt=%0d",
                     name, i, g.data, g.valid, g.err, g.cnt, e.data, e.valid, e.err, e.cnt);
         end
      end
   endtask

   task automatic test_reset();
      stim_t st[$];
      st.push_back(mk(1, 0, 0, 1, 2'd1, $urandom, $urandom, $urandom));
      st.push_back(mk(1, 0, 0, 1, 2'd2, $urandom, $urandom, $urandom));
      st.push_back(mk(0, 0, 0, 1, 2'd1, 32'h0, 32'hDEADBEEF, 32'h0));
      run_a("reset", st);
      checks++;
      if (bus_a.data_out !== 32'hDEADBEEF || bus_a.out_valid !== 1'b1) begin
         failures++;
         $display("FAIL reset_release: got data=%h v=%b, want data=deadbeef v=1",
                  bus_a.data_out, bus_a.out_valid);
      end
   endtask

   task automatic test_sweep();
      stim_t st[$];
      for (int s = 0; s < 3; s++)
         st.push_back(mk(0, 0, 0, 1, 2'(s), 32'h11, 32'h22, 32'h33));
      st.push_back(mk(0, 0, 0, 0, 2'd2, 32'h11, 32'h22, 32'h33));
      run_a("sweep", st);
   endtask

   task automatic test_oor();
      stim_t st[$];
      st.push_back(mk(0, 0, 0, 1, 2'd0, 32'h77, 0, 0));
      st.push_back(mk(0, 0, 0, 1, 2'd3, 32'h77, 32'h88, 32'h99));
      run_a("oor_zero", st);
      checks++;
      if (bus_a.data_out !== 32'h0 || bus_a.sel_err !== 1'b1 || bus_a.err_cnt !== 8'd1) begin
         failures++;
         $display("FAIL oor_zero_const: got data=%h e=%b cnt=%0d, want data=0 e=1 cnt=1",
                  bus_a.data_out, bus_a.sel_err, bus_a.err_cnt);
      end
      st.delete();
      st.push_back(mk(0, 0, 0, 0, 2'd3, 0, 0, 0));
      st.push_back(mk(0, 0, 0, 1, 2'd1, 0, 32'h5, 0));
      run_a("oor_recover", st);
   endtask

   task automatic test_stall_flush();
      stim_t st[$];
      st.push_back(mk(0, 0, 0, 1, 2'd0, 32'hAAAA, 0, 0));
      for (int i = 0; i < 3; i++)
         st.push_back(mk(0, 0, 1, 1, 2'd1, $urandom, $urandom, $urandom));
      st.push_back(mk(0, 1, 1, 1, 2'd2, 0, 0, 32'h1234));
      st.push_back(mk(0, 0, 0, 1, 2'd2, 0, 0, 32'h4321));
      st.push_back(mk(0, 0, 1, 1, 2'd3, 0, 0, 0));
      st.push_back(mk(0, 1, 0, 1, 2'd3, 0, 0, 0));
      run_a("stall_flush", st);
      checks++;
      if (bus_a.err_cnt !== 8'd1) begin
         failures++;
         $display("FAIL stall_flush_cnt: got cnt=%0d, want 1", bus_a.err_cnt);
      end
   endtask

   task automatic test_mid_reset();
      stim_t st[$];
      st.push_back(mk(0, 0, 0, 1, 2'd2, 0, 0, 32'hCAFE));
      st.push_back(mk(1, 0, 1, 1, 2'd3, 0, 0, 0));
      st.push_back(mk(0, 0, 0, 1, 2'd1, 0, 32'hBEEF, 0));
      run_a("mid_reset", st);
   endtask

   task automatic test_hold_policy();
      stim_t st[$];
      st.push_back(mk(0, 0, 0, 1, 2'd3, 0, 0, 0));
      st.push_back(mk(0, 0, 0, 1, 2'd0, 32'h55, 0, 0));
      st.push_back(mk(0, 0, 0, 1, 2'd3, 32'h66, 32'h77, 32'h88));
      run_b("oor_hold", st);
      checks++;
      if (bus_b.data_out !== 32'h55 || bus_b.err_cnt !== 2'd2 || bus_b.sel_err !== 1'b1) begin
         failures++;
         $display("FAIL oor_hold_const: got data=%h e=%b cnt=%0d, want data=55 e=1 cnt=2",
                  bus_b.data_out, bus_b.sel_err, bus_b.err_cnt);
      end
   endtask

   task automatic test_saturation();
      stim_t       st[$];
      logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      st.push_back(mk(1, 0, 0, 0, 2'd0, 0, 0, 0));
      run_b("sat_reset", st);
      st.delete();
      for (int i = 0; i < 5; i++) begin
         st.delete();
         st.push_back(mk(0, 0, 0, 1, 2'd3, 0, 0, 0));
         run_b("sat_step", st);
         checks++;
         if (bus_b.err_cnt !== want[i]) begin
            failures++;
            $display("FAIL saturation[%0d]: got cnt=%0d, want %0d", i, bus_b.err_cnt, want[i]);
         end
      end
   endtask

   task automatic test_width();
      logic [31:0] src = 32'h7E332211;
      logic [7:0]  e;
      for (int s = 3; s >= 0; s--) begin
         @(negedge clk);
         bus_c.sel      = 2'(s);
         bus_c.in_valid = 1'b1;
         bus_c.data_in  = src;
         q_c.push_back(src[s*8 +: 8]);
         @(posedge clk); #1;
         e = q_c.pop_front();
         checks++;
         if (bus_c.data_out !== e || bus_c.sel_err !== 1'b0 || bus_c.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL width sel=%0d: got data=%h e=%b v=%b, want data=%h e=0 v=1",
                     s, bus_c.data_out, bus_c.sel_err, bus_c.out_valid, e);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      bus_a.data_in = '0; bus_a.sel = '0; bus_a.in_valid = 0; bus_a.stall = 0; bus_a.flush = 0;
      bus_b.data_in = '0; bus_b.sel = '0; bus_b.in_valid = 0; bus_b.stall = 0; bus_b.flush = 0;
      bus_c.data_in = '0; bus_c.sel = '0; bus_c.in_valid = 0; bus_c.stall = 0; bus_c.flush = 0;
      test_reset();
      test_sweep();
      test_oor();
      test_stall_flush();
      test_mid_reset();
      test_hold_policy();
      test_saturation();
      test_width();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
